// File: rtl/video_timing_gen.sv
// video_timing_gen: free-running raster timing generator with registered, zero-skew sync/blank decode
module video_timing_gen #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP = 16,
  parameter int H_SYNC = 96,
  parameter int H_BP = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP = 10,
  parameter int V_SYNC = 2,
  parameter int V_BP = 33,
  parameter bit H_POL = 1'b0,
  parameter bit V_POL = 1'b0
) (
  input logic pixclk,
  input logic rst,
  output logic [11:0] CounterX,
  output logic [11:0] CounterY,
  output logic hSync,
  output logic vSync,
  output logic DrawArea,
  output logic animate,
  output logic frame_start,
  output logic [15:0] frame_cnt
);
  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HS_BEG = H_ACTIVE + H_FP;
  localparam int HS_END = HS_BEG + H_SYNC;
  localparam int VS_BEG = V_ACTIVE + V_FP;
  localparam int VS_END = VS_BEG + V_SYNC;
  if (H_TOTAL > 4096 || V_TOTAL > 4096) begin : g_size_err
    $error("video_timing_gen: H_TOTAL and V_TOTAL must each be <= 4096");
  end
  logic [11:0] nx, ny;
  logic x_wrap, y_wrap, fs_n;
  always_comb begin
    x_wrap = CounterX == 12'(H_TOTAL - 1);
    y_wrap = CounterY == 12'(V_TOTAL - 1);
    nx = x_wrap ? 12'd0 : CounterX + 12'd1;
    ny = x_wrap ? (y_wrap ? 12'd0 : CounterY + 12'd1) : CounterY;
    fs_n = nx == 12'd0 && ny == 12'd0;
  end
  always_ff @(posedge pixclk) begin
    if (rst) begin
      CounterX <= '0;
      CounterY <= '0;
      DrawArea <= 1'b0;
      hSync <= ~H_POL;
      vSync <= ~V_POL;
      animate <= 1'b0;
      frame_start <= 1'b0;
      frame_cnt <= '0;
    end else begin
      CounterX <= nx;
      CounterY <= ny;
      DrawArea <= int'(nx) < H_ACTIVE && int'(ny) < V_ACTIVE;
      hSync <= (int'(nx) >= HS_BEG && int'(nx) < HS_END) ? H_POL : ~H_POL;
      vSync <= (int'(ny) >= VS_BEG && int'(ny) < VS_END) ? V_POL : ~V_POL;
      animate <= nx == 12'd0 && int'(ny) == V_ACTIVE;
      frame_start <= fs_n;
      frame_cnt <= frame_cnt + 16'(fs_n);
    end
  end
endmodule

// File: tb/tb_video_timing_gen.sv
// tb_video_timing_gen: two reduced-size instances checked each cycle against a positional arithmetic model
module tb_video_timing_gen;
  localparam int AHA = 20, AHF = 3, AHS = 4, AHB = 5, AVA = 10, AVF = 2, AVS = 3, AVB = 4;
  localparam int AHT = AHA + AHF + AHS + AHB, AVT = AVA + AVF + AVS + AVB, AFT = AHT * AVT;
  localparam int BHA = 12, BHF = 2, BHS = 3, BHB = 3, BVA = 6, BVF = 1, BVS = 2, BVB = 2;
  localparam int BHT = BHA + BHF + BHS + BHB, BVT = BVA + BVF + BVS + BVB;
  logic pixclk = 1'b0;
  logic rst = 1'b1;
  logic [11:0] cx_a, cy_a, cx_b, cy_b;
  logic hs_a, vs_a, da_a, an_a, fs_a, hs_b, vs_b, da_b, an_b, fs_b;
  logic [15:0] fc_a, fc_b;
  int total = 0;
  int bad = 0;
  int p = 0;
  int off_a = 0;
  int off_b = 0;
  video_timing_gen #(
    .H_ACTIVE(AHA), .H_FP(AHF), .H_SYNC(AHS), .H_BP(AHB),
    .V_ACTIVE(AVA), .V_FP(AVF), .V_SYNC(AVS), .V_BP(AVB),
    .H_POL(1'b0), .V_POL(1'b0)
  ) dut_a (
    .pixclk(pixclk), .rst(rst), .CounterX(cx_a), .CounterY(cy_a), .hSync(hs_a), .vSync(vs_a),
    .DrawArea(da_a), .animate(an_a), .frame_start(fs_a), .frame_cnt(fc_a)
  );
  video_timing_gen #(
    .H_ACTIVE(BHA), .H_FP(BHF), .H_SYNC(BHS), .H_BP(BHB),
    .V_ACTIVE(BVA), .V_FP(BVF), .V_SYNC(BVS), .V_BP(BVB),
    .H_POL(1'b1), .V_POL(1'b1)
  ) dut_b (
    .pixclk(pixclk), .rst(rst), .CounterX(cx_b), .CounterY(cy_b), .hSync(hs_b), .vSync(vs_b),
    .DrawArea(da_b), .animate(an_b), .frame_start(fs_b), .frame_cnt(fc_b)
  );
  always #5 pixclk = ~pixclk;
  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed %0d expected %0d at position %0d", tag, obs, exp, p);
    end
  endtask
  task automatic check_dut(string nm, logic [11:0] cx, logic [11:0] cy, logic hs, logic vs,
                           logic da, logic an, logic fs, logic [15:0] fc,
                           int ha, int hf, int hsw, int ht, int va, int vf, int vsw, int vt,
                           bit hp, bit vp, int off);
    int x, y, ft;
    ft = ht * vt;
    x = p % ht;
    y = (p / ht) % vt;
    chk({nm, "_x"}, 32'(cx), 32'(x));
    chk({nm, "_y"}, 32'(cy), 32'(y));
    chk({nm, "_draw"}, 32'(da), 32'(p != 0 && x < ha && y < va));
    chk({nm, "_hsync"}, 32'(hs), 32'((x >= ha + hf && x < ha + hf + hsw) ? hp : !hp));
    chk({nm, "_vsync"}, 32'(vs), 32'((y >= va + vf && y < va + vf + vsw) ? vp : !vp));
    chk({nm, "_animate"}, 32'(an), 32'(p != 0 && x == 0 && y == va));
    chk({nm, "_fstart"}, 32'(fs), 32'(p != 0 && p % ft == 0));
    chk({nm, "_fcnt"}, 32'(fc), 32'((p / ft + off) % 65536));
  endtask
  task automatic cyc();
    @(posedge pixclk);
    p = rst ? 0 : p + 1;
    @(negedge pixclk);
    check_dut("a", cx_a, cy_a, hs_a, vs_a, da_a, an_a, fs_a, fc_a,
              AHA, AHF, AHS, AHT, AVA, AVF, AVS, AVT, 1'b0, 1'b0, off_a);
    check_dut("b", cx_b, cy_b, hs_b, vs_b, da_b, an_b, fs_b, fc_b,
              BHA, BHF, BHS, BHT, BVA, BVF, BVS, BVT, 1'b1, 1'b1, off_b);
  endtask
  task automatic run(int n);
    repeat (n) cyc();
  endtask
  initial begin
    rst = 1'b1;
    run(3);
    rst = 1'b0;
    run(2 * AFT + 40);
    for (int i = 0; i < 4; i++) begin
      run(int'($urandom_range(1, 900)));
      rst = 1'b1;
      run(int'($urandom_range(1, 3)));
      rst = 1'b0;
    end
    run((AVA + AVF + 1) * AHT + AHA + AHF + 1);
    rst = 1'b1;
    run(3);
    rst = 1'b0;
    run(AFT + 5);
    rst = 1'b1;
    run(1);
    rst = 1'b0;
    run(AFT - 1);
    force dut_a.frame_cnt = 16'hFFFF;
    #1 release dut_a.frame_cnt;
    off_a = 16'hFFFF;
    run(AFT + 10);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
